unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store port.
- Serialises requests and tracks the memory's variable-latency acknowledge.
- Emits a stall to freeze the core's PC register while any access is outstanding.
- Arbitration is round-robin when both ports request together. A watchdog aborts accesses the memory never acknowledges.

Parameters:
- AW, 32, address width of all ports.
- DW, 32, data width of all ports.
- TIMEOUT, 255, max cycles in BUSY before abort; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF, read data returned on an aborted access.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high until i_ready.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched instruction; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse, fetch port.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse, data port.
- m_valid  out  1  memory command valid; held until m_ack.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; sampled with m_ack.
- m_ack  in  1  memory completion, any latency ≥0 cycles after m_valid rises.
- stall  out  1  core stall = (i_req & ~i_ready) | (d_req & ~d_ready); combinational.
- err  out  1  sticky timeout flag.

Behaviour:

Reset:
- State IDLE. last_grant=FETCH, so data wins the first tie.
- m_valid=0, m_we=0, m_addr=0, m_wdata=0.
- i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, err=0, timeout counter=0.

States:
- IDLE
  - If exactly one req is high, grant it.
  - If both are high, grant the port not equal to last_grant.
  - At the edge: capture addr/we/wdata into the m_* registers (fetch forces m_we=0), set m_valid=1, record owner and last_grant, go to BUSY.
  - If no req, stay in IDLE.
- BUSY
  - m_* outputs are registered and stable; requester inputs are ignored.
  - Counter increments each cycle.
  - If m_ack is high at an edge: latch m_rdata into the owner's rdata register, clear m_valid and m_we, go to RESP.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: load ERR_DATA into the owner's rdata register, set err, clear m_valid, go to RESP.
- RESP
  - Owner's ready=1 for exactly this cycle; the other port's ready=0.
  - Counter cleared; return to IDLE unconditionally.
  - Requests are not evaluated in RESP. A req still high in the following IDLE cycle is a new transaction, so a requester deasserts req, or changes it to its next access, when it sees ready.

Latency and data:
- With m_ack in the first BUSY cycle: req cycle 0 (IDLE), m_valid cycle 1, ready cycle 2. Each extra memory wait cycle adds one.
- Stores complete the same way: d_ready pulses, and d_rdata holds the m_rdata value returned with the ack.
- i_rdata and d_rdata hold their last value outside ready cycles.

Boundary cases:
- m_ack while m_valid=0 (IDLE or RESP): ignored.
- m_ack in the same edge as timeout expiry: the ack wins; err is not set.
- err is cleared only by reset.
- Reset mid-access: all outputs clear asynchronously and the in-flight access is dropped with no ready pulse. The memory must tolerate m_valid falling without an ack.
- Back-to-back same-port requests: sustained throughput is 1 access per 3 cycles at zero memory wait.
- Alternating ties: strict F/D/F/D order after the first grant, which goes to data.

Test Plan:
1. Reset low → all outputs 0, state IDLE. Release, i_req=1, i_addr=0x100, m_ack one cycle after m_valid, m_rdata=0x00500093 → m_addr=0x100 and m_we=0 from cycle 1; i_ready pulses in cycle 3 with i_rdata=0x00500093; stall high cycles 0–2, low cycle 3.
2. i_req and d_req (load 0x2000) raised together from reset, memory acks immediately → data served first (d_ready cycle 2), fetch served next (i_ready cycle 5); repeating the tie gives order D,F,D,F.
3. Store d_we=1, d_addr=0x40, d_wdata=0xCAFEF00D, m_ack after 4 wait cycles → m_we=1, m_wdata=0xCAFEF00D held stable for all 5 BUSY cycles; d_ready pulses once; i_ready stays 0.
4. TIMEOUT=8, fetch with m_ack never asserted → m_valid drops after 8 BUSY cycles; i_ready pulses with i_rdata=0xDEADBEEF; err=1 and stays 1. The next access completes normally with err still 1.
5. m_ack on exactly the 8th BUSY cycle (TIMEOUT=8) → real m_rdata returned, err stays 0.
6. Reset asserted while BUSY with m_valid=1 → m_valid, ready and err go 0 immediately, before the next clk edge. After release, a pending d_req and i_req are re-arbitrated with data winning.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port memory between the instruction-fetch port and the
// load/store port. One access is in flight at a time; ties are broken
// round-robin, the core is stalled while a request is outstanding, and a
// watchdog aborts accesses the memory never acknowledges.
module unified_mem_arbiter #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_valid,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          stall,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // The watchdog counter only has to reach TIMEOUT-1.
  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            WD_EN   = (TIMEOUT != 0);

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_count;
  logic          r_ownerData;
  logic          r_lastData;
  logic          r_mValid;
  logic          r_mWe;
  logic [AW-1:0] r_mAddr;
  logic [DW-1:0] r_mWdata;
  logic [DW-1:0] r_iRdata;
  logic [DW-1:0] r_dRdata;
  logic          r_err;
  logic          w_grant;
  logic          w_grantData;
  logic          w_ack;
  logic          w_abort;

  // State register; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next state plus grant / completion / abort decisions for this cycle.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_grantData = 1'b0;
    w_ack       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_grant     = 1'b1;
          w_grantData = d_req && (!i_req || !r_lastData);
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (m_ack) begin
          w_ack       = 1'b1;
          w_nextState = RESP;
        end else if (WD_EN && (r_count == TO_LAST)) begin
          w_abort     = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Memory command registers, owner and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mValid    <= 1'b0;
      r_mWe       <= 1'b0;
      r_mAddr     <= '0;
      r_mWdata    <= '0;
      r_ownerData <= 1'b0;
      r_lastData  <= 1'b0;
    end else if (w_grant) begin
      r_mValid    <= 1'b1;
      r_mWe       <= w_grantData & d_we;
      r_mAddr     <= w_grantData ? d_addr : i_addr;
      r_mWdata    <= w_grantData ? d_wdata : '0;
      r_ownerData <= w_grantData;
      r_lastData  <= w_grantData;
    end else if (w_ack || w_abort) begin
      r_mValid <= 1'b0;
      r_mWe    <= 1'b0;
    end
  end

  // Return-data registers: memory data on ack, ERR_DATA on abort, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iRdata <= '0;
      r_dRdata <= '0;
    end else if (w_ack || w_abort) begin
      if (r_ownerData) r_dRdata <= w_ack ? m_rdata : ERR_DATA;
      else             r_iRdata <= w_ack ? m_rdata : ERR_DATA;
    end
  end

  // Watchdog counter runs only while an access stays in BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if ((r_state == BUSY) && (w_nextState == BUSY)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_err <= 1'b0;
    else if (w_abort) r_err <= 1'b1;
  end

  assign m_valid = r_mValid;
  assign m_we    = r_mWe;
  assign m_addr  = r_mAddr;
  assign m_wdata = r_mWdata;
  assign i_rdata = r_iRdata;
  assign d_rdata = r_dRdata;
  assign err     = r_err;
  assign i_ready = (r_state == RESP) && !r_ownerData;
  assign d_ready = (r_state == RESP) && r_ownerData;
  assign stall   = (i_req && !i_ready) || (d_req && !d_ready);

endmodule
